// File: rtl/cv32e40p_multi_clock_gate.sv
// cv32e40p_multi_clock_gate: N-channel activity-driven clock gating with wake handshake.
// Optional gated-cycle statistics when CV32E40P_CG_STATS_EN is defined.
module cv32e40p_multi_clock_gate #(
    parameter int NUM_CH      = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    scan_cg_en_i,
    input  logic [NUM_CH-1:0]       busy_i,
    input  logic [NUM_CH-1:0]       force_on_i,
`ifdef CV32E40P_CG_STATS_EN
    input  logic                    stats_clr_i,
    output logic [NUM_CH*CNT_W-1:0] gated_cycles_o,
`endif
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       ready_o,
    output logic [NUM_CH-1:0]       gated_o
);

    localparam int MAX_IW = IDLE_CYCLES > WAKE_CYCLES ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int MAX_C  = MAX_IW > 2 ? MAX_IW : 2;
    localparam int CW     = $clog2(MAX_C);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES > 0 ? WAKE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {RUN, IDLE_WAIT, GATED, WAKE} state_e;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          act, en, lat;

        assign act = busy_i[i] | force_on_i[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                RUN: begin
                    if (!act) begin
                        state_d = IDLE_WAIT;
                        cnt_d   = '0;
                    end
                end
                IDLE_WAIT: begin
                    if (act) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_d = GATED;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GATED: begin
                    if (act) begin
                        cnt_d = '0;
                        if (WAKE_CYCLES > 0) state_d = WAKE;
                        else                 state_d = RUN;
                    end
                end
                WAKE: begin
                    // activity is ignored here: a started wake always completes
                    if (cnt_q == WAKE_LAST) state_d = RUN;
                    else                    cnt_d   = cnt_q + 1'b1;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= RUN;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // enable comes from registered state only, latched during the low phase
        assign en = state_q != GATED;

        always_latch begin
            if (!clk_i) lat = en | scan_cg_en_i;
        end

        assign clk_o[i]   = clk_i & lat;
        assign ready_o[i] = (state_q == RUN) || (state_q == IDLE_WAIT);
        assign gated_o[i] = state_q == GATED;

`ifdef CV32E40P_CG_STATS_EN
        logic [CNT_W-1:0] stat_q, stat_d;

        always_comb begin
            stat_d = stats_clr_i ? '0 :
                     (state_q == GATED && stat_q != '1) ? stat_q + 1'b1 : stat_q;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) stat_q <= '0;
            else       stat_q <= stat_d;
        end

        assign gated_cycles_o[i*CNT_W +: CNT_W] = stat_q;
`endif
    end

endmodule
